// File: rtl/change_dispenser_if.sv
// Change-dispenser handshake bundle: transaction request, coin offer/ack and status.
// The master drives the request and ack; the slave is the dispenser.
interface change_dispenser_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] credit;
  logic [WIDTH-1:0] price;
  logic             coin_ack;
  logic             busy;
  logic             coin_valid;
  logic [1:0]       coin_type;
  logic             done;
  logic             short_err;
  logic [WIDTH-1:0] residue;
  logic [7:0]       coins_out;

  modport master (
    output start, credit, price, coin_ack,
    input  busy, coin_valid, coin_type, done, short_err, residue, coins_out
  );

  modport slave (
    input  start, credit, price, coin_ack,
    output busy, coin_valid, coin_type, done, short_err, residue, coins_out
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: computes credit - price, then offers quarters/dimes/nickels
// one per acked cycle until less than a nickel remains.
module change_dispenser #(
  parameter int WIDTH   = 8,
  parameter int NICKEL  = 5,
  parameter int DIME    = 10,
  parameter int QUARTER = 25
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   bus
);

  localparam logic [WIDTH-1:0] N_V = WIDTH'(NICKEL);
  localparam logic [WIDTH-1:0] D_V = WIDTH'(DIME);
  localparam logic [WIDTH-1:0] Q_V = WIDTH'(QUARTER);

  typedef enum logic [1:0] {IDLE, CALC, DISPENSE, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] credit_q, credit_d;
  logic [WIDTH-1:0] price_q, price_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] residue_q, residue_d;
  logic             short_q, short_d;
  logic [7:0]       coins_q, coins_d;

  logic [WIDTH:0]   diff;
  logic [1:0]       coin_sel;
  logic [WIDTH-1:0] coin_val;

  // Carry-out of the two's-complement subtraction is 1 exactly when credit >= price.
  assign diff = {1'b0, credit_q} + {1'b0, ~price_q} + (WIDTH+1)'(1);

  assign coin_sel = (remaining_q >= Q_V) ? 2'b11 :
                    (remaining_q >= D_V) ? 2'b10 : 2'b01;
  assign coin_val = (coin_sel == 2'b11) ? Q_V :
                    (coin_sel == 2'b10) ? D_V : N_V;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      price_q     <= '0;
      remaining_q <= '0;
      residue_q   <= '0;
      short_q     <= 1'b0;
      coins_q     <= '0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      price_q     <= price_d;
      remaining_q <= remaining_d;
      residue_q   <= residue_d;
      short_q     <= short_d;
      coins_q     <= coins_d;
    end
  end

  // Residue is loaded on entry to DONE so it is already valid while done is high.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    price_d     = price_q;
    remaining_d = remaining_q;
    residue_d   = residue_q;
    short_d     = short_q;
    coins_d     = coins_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          credit_d    = bus.credit;
          price_d     = bus.price;
          remaining_d = '0;
          residue_d   = '0;
          short_d     = 1'b0;
          coins_d     = '0;
          state_d     = CALC;
        end
      end
      CALC: begin
        if (!diff[WIDTH]) begin
          short_d     = 1'b1;
          remaining_d = '0;
          residue_d   = '0;
          state_d     = DONE;
        end else begin
          remaining_d = diff[WIDTH-1:0];
          if (diff[WIDTH-1:0] < N_V) begin
            residue_d = diff[WIDTH-1:0];
            state_d   = DONE;
          end else begin
            state_d   = DISPENSE;
          end
        end
      end
      DISPENSE: begin
        if (bus.coin_ack) begin
          remaining_d = remaining_q - coin_val;
          coins_d     = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
          if (remaining_d < N_V) begin
            residue_d = remaining_d;
            state_d   = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.coin_valid = (state_q == DISPENSE);
    bus.coin_type  = (state_q == DISPENSE) ? coin_sel : 2'b00;
    bus.done       = (state_q == DONE);
    bus.short_err  = (state_q == DONE) && short_q;
    bus.residue    = residue_q;
    bus.coins_out  = coins_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; samples outputs 1ns after each rising edge.
module tb_change_dispenser;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  change_dispenser_if #(.WIDTH(8)) bus ();

  change_dispenser #(.WIDTH(8), .NICKEL(5), .DIME(10), .QUARTER(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; on return the DUT is in CALC (cycle k+1).
  task automatic do_start(input logic [7:0] cr, input logic [7:0] pr);
    bus.start  = 1'b1;
    bus.credit = cr;
    bus.price  = pr;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    tests++; if (bus.coin_valid !== 1'b0) begin failed++; $display("FAIL reset_coin_valid got %b exp 0", bus.coin_valid); end
    tests++; if (bus.coin_type !== 2'b00) begin failed++; $display("FAIL reset_coin_type got %b exp 00", bus.coin_type); end
    tests++; if (bus.done !== 1'b0 || bus.short_err !== 1'b0) begin failed++; $display("FAIL reset_done_short got %b%b exp 00", bus.done, bus.short_err); end
    tests++; if (bus.residue !== 8'd0 || bus.coins_out !== 8'd0) begin failed++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.residue, bus.coins_out); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_greedy();
    bus.coin_ack = 1'b1;
    do_start(8'd100, 8'd60);
    tests++; if (bus.busy !== 1'b1 || bus.coin_valid !== 1'b0) begin failed++; $display("FAIL greedy_calc busy/valid got %b%b exp 10", bus.busy, bus.coin_valid); end
    tick();
    tests++; if (bus.coin_valid !== 1'b1 || bus.coin_type !== 2'b11) begin failed++; $display("FAIL greedy_coin1 got v=%b t=%b exp v=1 t=11", bus.coin_valid, bus.coin_type); end
    tick();
    tests++; if (bus.coin_valid !== 1'b1 || bus.coin_type !== 2'b10) begin failed++; $display("FAIL greedy_coin2 got v=%b t=%b exp v=1 t=10", bus.coin_valid, bus.coin_type); end
    tick();
    tests++; if (bus.coin_valid !== 1'b1 || bus.coin_type !== 2'b01) begin failed++; $display("FAIL greedy_coin3 got v=%b t=%b exp v=1 t=01", bus.coin_valid, bus.coin_type); end
    tick();
    tests++; if (bus.done !== 1'b1 || bus.short_err !== 1'b0 || bus.coin_valid !== 1'b0) begin failed++; $display("FAIL greedy_done got d=%b s=%b v=%b exp 1 0 0", bus.done, bus.short_err, bus.coin_valid); end
    tests++; if (bus.coins_out !== 8'd3 || bus.residue !== 8'd0) begin failed++; $display("FAIL greedy_totals got coins=%0d res=%0d exp 3 0", bus.coins_out, bus.residue); end
    tick();
    tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failed++; $display("FAIL greedy_idle got d=%b b=%b exp 0 0", bus.done, bus.busy); end
    bus.coin_ack = 1'b0;
  endtask

  task automatic test_short();
    do_start(8'd50, 8'd75);
    tests++; if (bus.coin_valid !== 1'b0 || bus.done !== 1'b0) begin failed++; $display("FAIL short_calc got v=%b d=%b exp 0 0", bus.coin_valid, bus.done); end
    tick();
    tests++; if (bus.done !== 1'b1 || bus.short_err !== 1'b1 || bus.coin_valid !== 1'b0) begin failed++; $display("FAIL short_done got d=%b s=%b v=%b exp 1 1 0", bus.done, bus.short_err, bus.coin_valid); end
    tests++; if (bus.coins_out !== 8'd0 || bus.residue !== 8'd0) begin failed++; $display("FAIL short_totals got coins=%0d res=%0d exp 0 0", bus.coins_out, bus.residue); end
    tick();
    tests++; if (bus.short_err !== 1'b0 || bus.done !== 1'b0) begin failed++; $display("FAIL short_pulse got s=%b d=%b exp 0 0", bus.short_err, bus.done); end
  endtask

  task automatic test_exact();
    do_start(8'd60, 8'd60);
    tick();
    tests++; if (bus.done !== 1'b1 || bus.short_err !== 1'b0 || bus.coin_valid !== 1'b0) begin failed++; $display("FAIL exact_done got d=%b s=%b v=%b exp 1 0 0", bus.done, bus.short_err, bus.coin_valid); end
    tests++; if (bus.coins_out !== 8'd0 || bus.residue !== 8'd0) begin failed++; $display("FAIL exact_totals got coins=%0d res=%0d exp 0 0", bus.coins_out, bus.residue); end
    tick();
    bus.coin_ack = 1'b1;
    do_start(8'd63, 8'd50);
    tick();
    tests++; if (bus.coin_valid !== 1'b1 || bus.coin_type !== 2'b10) begin failed++; $display("FAIL residue_dime got v=%b t=%b exp 1 10", bus.coin_valid, bus.coin_type); end
    tick();
    tests++; if (bus.done !== 1'b1 || bus.residue !== 8'd3 || bus.coins_out !== 8'd1) begin failed++; $display("FAIL residue_done got d=%b res=%0d coins=%0d exp 1 3 1", bus.done, bus.residue, bus.coins_out); end
    tick();
    bus.coin_ack = 1'b0;
    tests++; if (bus.residue !== 8'd3) begin failed++; $display("FAIL residue_hold got %0d exp 3", bus.residue); end
  endtask

  task automatic test_stall();
    bus.coin_ack = 1'b0;
    do_start(8'd40, 8'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.coin_valid !== 1'b1 || bus.coin_type !== 2'b11) begin failed++; $display("FAIL stall_hold[%0d] got v=%b t=%b exp 1 11", i, bus.coin_valid, bus.coin_type); end
      if (i < 4) tick();
    end
    bus.coin_ack = 1'b1;
    tick();
    tests++; if (bus.coin_type !== 2'b10) begin failed++; $display("FAIL stall_coin2 got %b exp 10", bus.coin_type); end
    tick();
    tests++; if (bus.coin_type !== 2'b01) begin failed++; $display("FAIL stall_coin3 got %b exp 01", bus.coin_type); end
    tick();
    tests++; if (bus.done !== 1'b1 || bus.coins_out !== 8'd3 || bus.residue !== 8'd0) begin failed++; $display("FAIL stall_done got d=%b coins=%0d res=%0d exp 1 3 0", bus.done, bus.coins_out, bus.residue); end
    tick();
    bus.coin_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.coin_ack = 1'b1;
    do_start(8'd100, 8'd60);
    tick();
    tests++; if (bus.coin_type !== 2'b11) begin failed++; $display("FAIL b2b_coin1 got %b exp 11", bus.coin_type); end
    do_start(8'd200, 8'd0);
    tests++; if (bus.coin_type !== 2'b10) begin failed++; $display("FAIL b2b_ignored_coin2 got %b exp 10", bus.coin_type); end
    tick();
    tests++; if (bus.coin_type !== 2'b01) begin failed++; $display("FAIL b2b_coin3 got %b exp 01", bus.coin_type); end
    tick();
    tests++; if (bus.done !== 1'b1 || bus.coins_out !== 8'd3) begin failed++; $display("FAIL b2b_done got d=%b coins=%0d exp 1 3", bus.done, bus.coins_out); end
    tick();
    // Immediate restart from IDLE right after done.
    do_start(8'd30, 8'd20);
    tick();
    tests++; if (bus.coin_type !== 2'b10 || bus.coins_out !== 8'd0) begin failed++; $display("FAIL b2b_restart got t=%b coins=%0d exp 10 0", bus.coin_type, bus.coins_out); end
    tick();
    tests++; if (bus.done !== 1'b1 || bus.coins_out !== 8'd1 || bus.residue !== 8'd0) begin failed++; $display("FAIL b2b_restart_done got d=%b coins=%0d res=%0d exp 1 1 0", bus.done, bus.coins_out, bus.residue); end
    tick();
    bus.coin_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    bus.coin_ack = 1'b1;
    do_start(8'd100, 8'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.coin_valid !== 1'b0 || bus.coin_type !== 2'b00) begin failed++; $display("FAIL rstmid_async got b=%b v=%b t=%b exp 0 0 00", bus.busy, bus.coin_valid, bus.coin_type); end
    tests++; if (bus.coins_out !== 8'd0 || bus.residue !== 8'd0 || bus.done !== 1'b0) begin failed++; $display("FAIL rstmid_clear got coins=%0d res=%0d d=%b exp 0 0 0", bus.coins_out, bus.residue, bus.done); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done !== 1'b0) done_seen++;
      tick();
    end
    tests++; if (done_seen !== 0) begin failed++; $display("FAIL rstmid_no_done got %0d pulses exp 0", done_seen); end
    do_start(8'd63, 8'd50);
    tick();
    tests++; if (bus.coin_type !== 2'b10 || bus.coins_out !== 8'd0) begin failed++; $display("FAIL rstmid_restart got t=%b coins=%0d exp 10 0", bus.coin_type, bus.coins_out); end
    tick();
    tests++; if (bus.done !== 1'b1 || bus.residue !== 8'd3 || bus.coins_out !== 8'd1) begin failed++; $display("FAIL rstmid_restart_done got d=%b res=%0d coins=%0d exp 1 3 1", bus.done, bus.residue, bus.coins_out); end
    tick();
    bus.coin_ack = 1'b0;
  endtask

  task automatic test_max();
    bus.coin_ack = 1'b1;
    do_start(8'd255, 8'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      tests++; if (bus.coin_valid !== 1'b1 || bus.coin_type !== 2'b11) begin failed++; $display("FAIL max_quarter[%0d] got v=%b t=%b exp 1 11", i, bus.coin_valid, bus.coin_type); end
      tick();
    end
    tests++; if (bus.coin_valid !== 1'b1 || bus.coin_type !== 2'b01) begin failed++; $display("FAIL max_nickel got v=%b t=%b exp 1 01", bus.coin_valid, bus.coin_type); end
    tick();
    tests++; if (bus.done !== 1'b1 || bus.coins_out !== 8'd11 || bus.residue !== 8'd0) begin failed++; $display("FAIL max_done got d=%b coins=%0d res=%0d exp 1 11 0", bus.done, bus.coins_out, bus.residue); end
    tick();
    bus.coin_ack = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.short_err !== 1'b0) begin failed++; $display("FAIL max_idle got b=%b s=%b exp 0 0", bus.busy, bus.short_err); end
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.credit   = '0;
    bus.price    = '0;
    bus.coin_ack = 1'b0;
    test_reset();
    test_greedy();
    test_short();
    test_exact();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_max();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
